muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Iterative RV32M multiply/divide unit in the EX stage, beside the ALU. Takes R-type M_INSTR ops
//  (funct7 == M_INSTR) with forwarded rs1/rs2 and returns the 32-bit rd value over valid/ready.
//  The hazard unit stalls EX while busy. Implementing this block sets M_SUPPORT to TRUE.
// PARAMETERS
//  XLEN   32   operand/result width; only 32 is supported
// PORTS
//  clk        in   1     core clock
//  rst_n      in   1     synchronous, active-low reset
//  flush      in   1     synchronous kill of any in-flight op (branch mispredict/trap)
//  in_valid   in   1     op request
//  in_ready   out  1     unit idle, accepts request
//  funct3     in   3     MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU
//  rs1_data   in   XLEN  operand a (dividend/multiplicand)
//  rs2_data   in   XLEN  operand b (divisor/multiplier)
//  out_valid  out  1     result available
//  out_ready  in   1     consumer takes result
//  result     out  XLEN  rd value
// BEHAVIOUR
//  - Clock: one clock. Reset: synchronous, active-low. Reset puts state in IDLE with in_ready=1,
//    out_valid=0, result=0, counter=0.
//  - Accept: in_valid & in_ready at a rising edge. Operands and funct3 are latched at that edge.
//    in_ready is 1 only in IDLE.
//  - FSM states: IDLE -> CALC -> FIX -> DONE -> IDLE.
//    - CALC runs 32 iterations with a 5-bit counter, from 0 up to 31.
//    - FIX applies sign correction and selects the result.
//    - DONE holds out_valid=1 with result stable until out_ready. It returns to IDLE on the edge
//      where out_valid & out_ready; no new accept happens on that same edge.
//  - Latency: out_valid goes high 34 cycles after the accept edge (32 CALC + FIX + DONE entry).
//  - Sign handling: operands are converted to magnitudes, the core iterates unsigned, and FIX
//    negates.
//    - MULH: both operands signed. MULHSU: rs1 signed, rs2 unsigned. MULHU: both unsigned.
//    - MUL returns product[31:0]; MULH, MULHSU and MULHU return product[63:32] (64-bit product).
//    - DIV/REM: quotient truncates toward zero; the remainder takes the sign of the dividend.
//  - Special cases go IDLE -> DONE directly, with out_valid 1 cycle after accept:
//    - divide by zero: quotient = 0xFFFF_FFFF, remainder = rs1 (signed and unsigned forms).
//    - signed overflow (0x8000_0000 / 0xFFFF_FFFF): quotient = 0x8000_0000, remainder = 0.
//  - flush has priority over every other event.
//    - Any state goes to IDLE at the next edge; out_valid=0 and the result is discarded.
//    - A request presented in the same cycle as flush is not accepted.
//  - rst_n low mid-operation gives exactly the reset values at the next edge.
//  - Inputs are ignored while not in IDLE. result is don't-care whenever out_valid=0.
// CONFIGURATION
//  - MULDIV_DSP_MUL_EN defined: multiplies use a single registered 32x32 -> 64 DSP product.
//    Path is IDLE -> FIX -> DONE, out_valid 2 cycles after accept. Divides are unchanged.
//  - MULDIV_DSP_MUL_EN undefined: multiplies use the 32-cycle shift-add path (34-cycle latency).
//  - Results are identical in both builds.
// STRUCTURE
//  - Shared package (defines), additions:
//    - muldiv_state_t enum {IDLE, CALC, FIX, DONE}
//    - localparam MULDIV_ITERS = XLEN
//    - M-extension funct3 constants, which already exist there
//  - Sub-module muldiv_iter_core: one-bit-per-cycle shift-add multiplier and restoring divider
//    datapath. It holds the 64-bit accumulator/remainder register and the 32-bit quotient
//    register. It is stepped by the parent FSM.
//  - muldiv_unit owns the FSM, counter, special-case detection, sign fix and handshake.
// TESTING
//  1. MUL  7 * 0xFFFF_FFFD -> 0xFFFF_FFEB. out_valid exactly 34 cycles after accept (2 with DSP).
//  2. MULH 0x8000_0000 * 0x8000_0000 -> 0x4000_0000. MULHU 0xFFFF_FFFF^2 -> 0xFFFF_FFFE.
//     MULHSU 0xFFFF_FFFF * 2 -> 0xFFFF_FFFF.
//  3. DIV -7/2 -> 0xFFFF_FFFD. REM -7,2 -> 0xFFFF_FFFF. DIVU 100/7 -> 14. REMU 100,7 -> 2.
//  4. DIVU 5/0 -> 0xFFFF_FFFF, REM 5,0 -> 5, DIV 0x8000_0000/-1 -> 0x8000_0000, REM -> 0.
//     Each has out_valid 1 cycle after accept.
//  5. out_ready held low 5 cycles in DONE: out_valid and result stay stable, in_ready stays 0.
//     Handshake then gives in_ready=1 on the next cycle.
//  6. flush at CALC counter=10 -> IDLE next edge, no out_valid. A flush+in_valid cycle is not
//     accepted. rst_n=0 mid-DIV -> reset values.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: width, iteration count,
// M-extension funct3 encodings and the unit FSM state type.
package muldiv_unit_pkg;

   localparam int unsigned XLEN         = 32;
   localparam int unsigned MULDIV_ITERS = XLEN;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } muldiv_state_t;

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
interface muldiv_unit_if;
   import muldiv_unit_pkg::*;

   logic            in_valid;
   logic            in_ready;
   logic [2:0]      funct3;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] result;

   modport master (
      output in_valid, funct3, rs1_data, rs2_data, out_ready,
      input  in_ready, out_valid, result
   );

   modport slave (
      input  in_valid, funct3, rs1_data, rs2_data, out_ready,
      output in_ready, out_valid, result
   );

endinterface

// File: rtl/muldiv_iter_core.sv
// One-bit-per-cycle datapath: shift-add multiplier and restoring divider on unsigned
// magnitudes. After 32 steps acc holds the 64-bit product (multiply) or the remainder
// in acc[63:32] with the quotient in quo (divide). Stepped by muldiv_unit.
module muldiv_iter_core
   import muldiv_unit_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              step,
   input  logic              is_div,
   input  logic [XLEN-1:0]   a_mag,
   input  logic [XLEN-1:0]   b_mag,
   output logic [2*XLEN-1:0] acc,
   output logic [XLEN-1:0]   quo
);

   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0]   quo_q, quo_d;
   logic [XLEN-1:0]   opb_q, opb_d;
   logic [XLEN:0]     add_sum;
   logic [XLEN:0]     trial;
   logic [2*XLEN-1:0] shl;

   // Next-state for accumulator, quotient and the held multiplicand/divisor.
   always_comb begin
      acc_d   = acc_q;
      quo_d   = quo_q;
      opb_d   = opb_q;
      add_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
      shl     = {acc_q[2*XLEN-2:0], 1'b0};
      // 33-bit trial: partial remainder doubled plus next dividend bit can exceed 32 bits.
      trial   = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opb_q};
      if (load) begin
         acc_d = {{XLEN{1'b0}}, a_mag};
         quo_d = '0;
         opb_d = b_mag;
      end else if (step) begin
         if (is_div) begin
            if (!trial[XLEN]) begin
               acc_d = {trial[XLEN-1:0], shl[XLEN-1:0]};
               quo_d = {quo_q[XLEN-2:0], 1'b1};
            end else begin
               acc_d = shl;
               quo_d = {quo_q[XLEN-2:0], 1'b0};
            end
         end else begin
            acc_d = {add_sum, acc_q[XLEN-1:1]};
         end
      end
   end

   // Datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_q <= '0;
         quo_q <= '0;
         opb_q <= '0;
      end else begin
         acc_q <= acc_d;
         quo_q <= quo_d;
         opb_q <= opb_d;
      end
   end

   assign acc = acc_q;
   assign quo = quo_q;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: FSM, iteration counter, special-case detection,
// sign correction and valid/ready handshake. Optional build macro MULDIV_DSP_MUL_EN
// replaces the iterative multiply with a single registered 32x32 product.
module muldiv_unit
   import muldiv_unit_pkg::*;
(
   input  logic           clk,
   input  logic           rst_n,
   input  logic           flush,
   muldiv_unit_if.slave   bus
);

   muldiv_state_t     state_q, state_d;
   logic [4:0]        cnt_q, cnt_d;
   logic [XLEN-1:0]   result_q, result_d;
   logic [2:0]        f3_q, f3_d;
   logic              neg_q, neg_d;

   logic              accept;
   logic              in_is_div, in_is_rem;
   logic              a_sgn, b_sgn;
   logic [XLEN-1:0]   a_mag, b_mag;
   logic              div_by_zero, div_ovf;
   logic              core_load, core_step;
   logic [2*XLEN-1:0] core_acc;
   logic [XLEN-1:0]   core_quo;
   logic [2*XLEN-1:0] mul_raw, mul_fix;
   logic [XLEN-1:0]   quo_fix, rem_fix, fix_result;

   assign accept    = bus.in_valid && (state_q == IDLE) && !flush;
   assign in_is_div = bus.funct3[2];
   assign in_is_rem = bus.funct3[2] && bus.funct3[1];

   // Operand signedness by op; magnitudes feed the unsigned core.
   always_comb begin
      a_sgn = 1'b0;
      b_sgn = 1'b0;
      case (bus.funct3)
         F3_MULH, F3_DIV, F3_REM: begin
            a_sgn = bus.rs1_data[XLEN-1];
            b_sgn = bus.rs2_data[XLEN-1];
         end
         F3_MULHSU: a_sgn = bus.rs1_data[XLEN-1];
         default: ;
      endcase
      a_mag = a_sgn ? -bus.rs1_data : bus.rs1_data;
      b_mag = b_sgn ? -bus.rs2_data : bus.rs2_data;
   end

   assign div_by_zero = in_is_div && (bus.rs2_data == '0);
   assign div_ovf     = in_is_div && !bus.funct3[0] && (bus.rs1_data == 32'h8000_0000)
                        && (bus.rs2_data == '1);

   muldiv_iter_core u_core (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (core_load),
      .step   (core_step),
      .is_div (f3_q[2]),
      .a_mag  (a_mag),
      .b_mag  (b_mag),
      .acc    (core_acc),
      .quo    (core_quo)
   );

`ifdef MULDIV_DSP_MUL_EN
   logic [2*XLEN-1:0] dsp_q;

   // Single-cycle product captured at accept; divides ignore it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dsp_q <= '0;
      end else if (accept) begin
         dsp_q <= {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
      end
   end

   assign mul_raw = dsp_q;
`else
   assign mul_raw = core_acc;
`endif

   // Sign correction and result selection used in FIX.
   always_comb begin
      mul_fix = neg_q ? -mul_raw : mul_raw;
      quo_fix = neg_q ? -core_quo : core_quo;
      rem_fix = neg_q ? -core_acc[2*XLEN-1:XLEN] : core_acc[2*XLEN-1:XLEN];
      case (f3_q)
         F3_MUL:                      fix_result = mul_fix[XLEN-1:0];
         F3_MULH, F3_MULHSU, F3_MULHU: fix_result = mul_fix[2*XLEN-1:XLEN];
         F3_DIV, F3_DIVU:             fix_result = quo_fix;
         default:                     fix_result = rem_fix;
      endcase
   end

   // FSM next-state, counter, latched op info and result register.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      result_d  = result_q;
      f3_d      = f3_q;
      neg_d     = neg_q;
      core_load = 1'b0;
      core_step = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               f3_d      = bus.funct3;
               // Remainder follows the dividend; quotient/product follow both signs.
               neg_d     = in_is_rem ? a_sgn : (a_sgn ^ b_sgn);
               cnt_d     = '0;
               core_load = 1'b1;
               if (div_by_zero) begin
                  result_d = in_is_rem ? bus.rs1_data : '1;
                  state_d  = DONE;
               end else if (div_ovf) begin
                  result_d = in_is_rem ? '0 : 32'h8000_0000;
                  state_d  = DONE;
               end
`ifdef MULDIV_DSP_MUL_EN
               else if (!in_is_div) begin
                  state_d = FIX;
               end
`endif
               else begin
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            core_step = 1'b1;
            cnt_d     = cnt_q + 5'd1;
            if (cnt_q == 5'(MULDIV_ITERS - 1)) begin
               state_d = FIX;
            end
         end
         FIX: begin
            result_d = fix_result;
            state_d  = DONE;
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (flush) begin
         state_d   = IDLE;
         cnt_d     = '0;
         result_d  = '0;
         core_load = 1'b0;
         core_step = 1'b0;
      end
   end

   // Control state registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         result_q <= '0;
         f3_q     <= '0;
         neg_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         f3_q     <= f3_d;
         neg_q    <= neg_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.result    = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table plus hand-written sequences
// for output backpressure, flush and mid-operation reset.
module tb_muldiv_unit;
   import muldiv_unit_pkg::*;

`ifdef MULDIV_DSP_MUL_EN
   localparam int MUL_LAT = 2;
`else
   localparam int MUL_LAT = 34;
`endif
   localparam int DIV_LAT = 34;
   localparam int SPC_LAT = 1;

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   logic clk;
   logic rst_n;
   logic flush;
   int   checks;
   int   failures;
   vec_t vecs[$];

   muldiv_unit_if bus ();

   muldiv_unit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic add(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp, input int lat);
      vec_t v;
      v.f3 = f3; v.a = a; v.b = b; v.exp = exp; v.lat = lat;
      vecs.push_back(v);
   endtask

   // Issue one op, wait for out_valid (lat counts negedge samples after the accept edge),
   // then consume the result.
   task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.funct3   = f3;
      bus.rs1_data = a;
      bus.rs2_data = b;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      lat = -1;
      res = 32'hDEAD_BEEF;
      for (int i = 1; i <= 100; i++) begin
         @(negedge clk);
         if (bus.out_valid) begin
            lat = i;
            break;
         end
      end
      if (lat > 0) begin
         res = bus.result;
         bus.out_ready = 1'b1;
         @(posedge clk);
         #1;
         bus.out_ready = 1'b0;
      end else begin
         flush = 1'b1;
         @(posedge clk);
         #1;
         flush = 1'b0;
      end
   endtask

   initial begin
      logic [31:0] res;
      int          lat;
      int          seen;

      checks        = 0;
      failures      = 0;
      rst_n         = 1'b0;
      flush         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.funct3    = '0;
      bus.rs1_data  = '0;
      bus.rs2_data  = '0;
      bus.out_ready = 1'b0;

      add(F3_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
      add(F3_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, MUL_LAT);
      add(F3_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT);
      add(F3_MULH,   32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, MUL_LAT);
      add(F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
      add(F3_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, MUL_LAT);
      add(F3_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, DIV_LAT);
      add(F3_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, DIV_LAT);
      add(F3_DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, DIV_LAT);
      add(F3_REM,    32'd7,         32'hFFFF_FFFE, 32'h0000_0001, DIV_LAT);
      add(F3_DIVU,   32'd100,       32'd7,         32'd14,        DIV_LAT);
      add(F3_REMU,   32'd100,       32'd7,         32'd2,         DIV_LAT);
      add(F3_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, SPC_LAT);
      add(F3_REM,    32'd5,         32'd0,         32'd5,         SPC_LAT);
      add(F3_DIV,    32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, SPC_LAT);
      add(F3_REMU,   32'd7,         32'd0,         32'd7,         SPC_LAT);
      add(F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPC_LAT);
      add(F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, SPC_LAT);

      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("reset_in_ready", 32'(bus.in_ready), 32'd1);
      check("reset_out_valid", 32'(bus.out_valid), 32'd0);
      check("reset_result", bus.result, 32'd0);

      foreach (vecs[i]) begin
         run_op(vecs[i].f3, vecs[i].a, vecs[i].b, res, lat);
         check($sformatf("vec%0d_result", i), res, vecs[i].exp);
         check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      end

      // Backpressure: hold out_ready low in DONE; a request meanwhile must be ignored.
      @(negedge clk);
      bus.in_valid = 1'b1; bus.funct3 = F3_DIVU; bus.rs1_data = 32'd100; bus.rs2_data = 32'd7;
      @(posedge clk);
      #1;
      bus.funct3 = F3_MUL; bus.rs1_data = 32'd3; bus.rs2_data = 32'd3;
      seen = 0;
      for (int i = 0; i < 100 && seen == 0; i++) begin
         @(negedge clk);
         if (bus.out_valid) seen = 1;
      end
      check("bp_reached_done", 32'(seen), 32'd1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check($sformatf("bp_hold%0d_valid", i), 32'(bus.out_valid), 32'd1);
         check($sformatf("bp_hold%0d_result", i), bus.result, 32'd14);
         check($sformatf("bp_hold%0d_in_ready", i), 32'(bus.in_ready), 32'd0);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      @(negedge clk);
      check("bp_after_in_ready", 32'(bus.in_ready), 32'd1);
      check("bp_after_out_valid", 32'(bus.out_valid), 32'd0);
      bus.in_valid = 1'b0;

      // Flush while CALC counter is 10.
      @(negedge clk);
      bus.in_valid = 1'b1; bus.funct3 = F3_DIV; bus.rs1_data = 32'd1000; bus.rs2_data = 32'd3;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      @(negedge clk);
      check("flush_in_ready", 32'(bus.in_ready), 32'd1);
      check("flush_out_valid", 32'(bus.out_valid), 32'd0);

      // Request coincident with flush must not be accepted.
      bus.in_valid = 1'b1; bus.funct3 = F3_DIVU; bus.rs1_data = 32'd9; bus.rs2_data = 32'd0;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      bus.in_valid = 1'b0;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.out_valid || !bus.in_ready) seen = 1;
      end
      check("flush_req_ignored", 32'(seen), 32'd0);

      // Reset mid-divide returns reset values.
      run_op(F3_DIVU, 32'd100, 32'd7, res, lat);
      check("pre_reset_result", res, 32'd14);
      @(negedge clk);
      bus.in_valid = 1'b1; bus.funct3 = F3_DIV; bus.rs1_data = 32'd50; bus.rs2_data = 32'd5;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_result", bus.result, 32'd0);
      run_op(F3_REMU, 32'd100, 32'd7, res, lat);
      check("post_reset_result", res, 32'd2);
      check("post_reset_latency", 32'(lat), 32'(DIV_LAT));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
